// File: rtl/ysyx_23060072_dmem_responder.sv
// Data-memory responder for the LSU: one request at a time, fixed access latency,
// byte-masked stores and word loads on an internal array, error on out-of-range.
module ysyx_23060072_dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_wstrb_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o
);
  localparam int          IW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT    = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        r_state, w_nstate;
  logic [3:0]    r_cnt;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_wstrb;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_accept;
  logic          w_fire;
  logic          w_hit;
  logic [IW-1:0] w_idx;

  // 33-bit upper bound so a range ending at the top of the address space cannot wrap
  assign w_hit = (r_addr >= BASE_ADDR) && ({1'b0, r_addr} < LIMIT);
  assign w_idx = IW'((r_addr - BASE_ADDR) >> 2);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nstate;
  end

  always_comb begin
    w_nstate     = r_state;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    w_accept     = 1'b0;
    w_fire       = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          w_accept = 1'b1;
          w_nstate = BUSY;
        end
      end
      BUSY: begin
        if (r_cnt == 4'd0) begin
          w_fire   = 1'b1;
          w_nstate = RESP;
        end
      end
      RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) w_nstate = IDLE;
      end
      default: w_nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_wstrb <= 4'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we    <= req_we_i;
        r_addr  <= req_addr_i;
        r_wdata <= req_wdata_i;
        r_wstrb <= req_wstrb_i;
        r_cnt   <= CNT_INIT;
      end
      if (r_state == BUSY && r_cnt != 4'd0) r_cnt <= 4'(r_cnt - 4'd1);
      if (w_fire) begin
        r_err   <= ~w_hit;
        r_rdata <= (w_hit && !r_we) ? r_mem[w_idx] : 32'd0;
      end
      if (r_state == RESP && resp_ready_i) begin
        r_rdata <= 32'd0;
        r_err   <= 1'b0;
      end
    end
  end

  // Array is deliberately left out of reset; reset only suppresses the pending write
  always_ff @(posedge clk) begin
    if (!rst && w_fire && w_hit && r_we) begin
      for (int n = 0; n < 4; n++)
        if (r_wstrb[n]) r_mem[w_idx][8*n +: 8] <= r_wdata[8*n +: 8];
    end
  end

  assign resp_rdata_o = r_rdata;
  assign resp_err_o   = r_err;
endmodule

// File: tb/tb_ysyx_23060072_dmem_responder.sv
// Scoreboard bench for the dmem responder: expected responses are queued at accept
// and compared when the response appears.
module tb_ysyx_23060072_dmem_responder;
  localparam int          LATENCY = 2;
  localparam logic [31:0] BASE    = 32'h8000_0000;
  localparam logic [31:0] TOP     = 32'h8000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready_o;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_wstrb = 4'd0;
  logic        resp_valid_o;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;

  int vectors = 0;
  int miscompares = 0;

  logic [32:0] sb [$];
  logic [32:0] last_exp;
  logic [31:0] mdl [int];

  ysyx_23060072_dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LATENCY), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o)
  );

  always #5 clk = ~clk;

  task automatic push_expected(input logic we, input logic [31:0] a, input logic [31:0] wd,
                               input logic [3:0] st);
    int idx;
    logic [31:0] w;
    idx = int'((a - BASE) >> 2);
    if (a < BASE || a >= TOP) sb.push_back({32'd0, 1'b1});
    else if (we) begin
      w = mdl.exists(idx) ? mdl[idx] : 32'd0;
      for (int n = 0; n < 4; n++) if (st[n]) w[8*n +: 8] = wd[8*n +: 8];
      mdl[idx] = w;
      sb.push_back({32'd0, 1'b0});
    end else sb.push_back({mdl.exists(idx) ? mdl[idx] : 32'd0, 1'b0});
  endtask

  // Issue one request and wait for its response (left pending, not yet acknowledged)
  task automatic send(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st);
    int n;
    n = 0;
    while (!req_ready_o && n < 50) begin @(posedge clk); #1; n++; end
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_wstrb = st;
    @(posedge clk);
    push_expected(we, a, wd, st);
    #1 req_valid = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!resp_valid_o && n < 40);
    vectors++;
    if (n !== LATENCY) begin
      miscompares++;
      $display("FAIL latency addr=%h got %0d cycles want %0d", a, n, LATENCY);
    end
    last_exp = sb.pop_front();
    vectors++;
    if ({resp_rdata_o, resp_err_o} !== last_exp) begin
      miscompares++;
      $display("FAIL resp addr=%h got rdata=%h err=%b want rdata=%h err=%b",
               a, resp_rdata_o, resp_err_o, last_exp[32:1], last_exp[0]);
    end
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    vectors++;
    if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || resp_rdata_o !== 32'd0 || resp_err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL release got valid=%b ready=%b rdata=%h err=%b want 0 1 0 0",
               resp_valid_o, req_ready_o, resp_rdata_o, resp_err_o);
    end
  endtask

  task automatic xfer(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
    send(we, a, wd, st);
    finish_resp();
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    vectors++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0 || resp_rdata_o !== 32'd0 || resp_err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset got ready=%b valid=%b rdata=%h err=%b want 1 0 0 0",
               req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o);
    end
  endtask

  task automatic test_store_load();
    xfer(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
    xfer(1'b0, 32'h8000_0010, 32'h0, 4'h0);
    vectors++;
    if (last_exp[32:1] !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL model_store_load got %h want deadbeef", last_exp[32:1]);
    end
  endtask

  task automatic test_byte_store();
    xfer(1'b1, 32'h8000_0010, 32'h1122_3344, 4'hF);
    xfer(1'b1, 32'h8000_0012, 32'h00AB_0000, 4'b0100);
    xfer(1'b0, 32'h8000_0010, 32'h0, 4'h0);
    vectors++;
    if (last_exp[32:1] !== 32'h11AB_3344) begin
      miscompares++;
      $display("FAIL model_byte got %h want 11ab3344", last_exp[32:1]);
    end
    xfer(1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'b0000);
    xfer(1'b0, 32'h8000_0010, 32'h0, 4'h0);
    xfer(1'b1, 32'h8000_0011, 32'h0000_5500, 4'b0010);
    xfer(1'b0, 32'h8000_0013, 32'h0, 4'h0);
  endtask

  task automatic test_out_of_range();
    xfer(1'b1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF);
    xfer(1'b1, 32'h8000_0FFC, 32'h0BAD_C0DE, 4'hF);
    xfer(1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0);
    xfer(1'b0, 32'h8000_1000, 32'h0, 4'h0);
    xfer(1'b1, 32'h8000_1000, 32'h1234_5678, 4'hF);
    xfer(1'b1, 32'h7FFF_FFFC, 32'h8765_4321, 4'hF);
    xfer(1'b0, 32'h8000_0000, 32'h0, 4'h0);
    xfer(1'b0, 32'h8000_0FFC, 32'h0, 4'h0);
    xfer(1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0);
  endtask

  task automatic test_backpressure();
    send(1'b0, 32'h8000_0010, 32'h0, 4'h0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (resp_valid_o !== 1'b1 || req_ready_o !== 1'b0 || {resp_rdata_o, resp_err_o} !== last_exp) begin
        miscompares++;
        $display("FAIL backpressure cyc=%0d got valid=%b ready=%b rdata=%h err=%b want 1 0 %h %b",
                 c, resp_valid_o, req_ready_o, resp_rdata_o, resp_err_o, last_exp[32:1], last_exp[0]);
      end
    end
    finish_resp();
  endtask

  task automatic test_reset_busy();
    xfer(1'b1, 32'h8000_0020, 32'h0, 4'hF);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8000_0020; req_wdata = 32'hFFFF_FFFF; req_wstrb = 4'hF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_busy cyc=%0d got valid=%b ready=%b want 0 1", c, resp_valid_o, req_ready_o);
      end
      @(posedge clk); #1;
    end
    xfer(1'b0, 32'h8000_0020, 32'h0, 4'h0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    for (int i = 0; i < 8; i++) xfer(1'b1, BASE + 32'(i * 4), $urandom, 4'hF);
    for (int i = 0; i < 24; i++) begin
      a = BASE + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) xfer(1'b1, a, $urandom, 4'($urandom_range(0, 15)));
      else                           xfer(1'b0, a, 32'h0, 4'h0);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_store();
    test_out_of_range();
    test_backpressure();
    test_reset_busy();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
